// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll controller.
// Contents:
//   state_e        - controller FSM state encoding
//   DEF_*          - default timing parameters (100 MHz system clock)
//   mod6_face()    - maps a raw nibble onto a dice face 1..6
package dice_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRoll = 2'd1,
        StHold = 2'd2
    } state_e;

    localparam int unsigned DEF_DB_CYCLES   = 500000;   // 5 ms debounce
    localparam int unsigned DEF_STEP_CYCLES = 1000000;  // first tumble interval
    localparam int unsigned DEF_ROLL_STEPS  = 8;        // samples per roll

    // (n mod 6) + 1 without a divider; n is at most 15, so two subtractions suffice.
    function automatic logic [3:0] mod6_face(input logic [3:0] n);
        logic [3:0] r;
        if (n >= 4'd12) begin
            r = n - 4'd12;
        end else if (n >= 4'd6) begin
            r = n - 4'd6;
        end else begin
            r = n;
        end
        return r + 4'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, counter debounce and a
// one-cycle pulse on each rising edge of the debounced level.
// Parameters:
//   DB_CYCLES  - consecutive differing synchronized samples needed to flip level
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   btn_in     - raw asynchronous button
//   level      - debounced button level
//   rise_pulse - high for one cycle on the first cycle level reads 1
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise_pulse
);

    localparam int unsigned CW = $clog2(DB_CYCLES) + 1;

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_in};
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample agreeing with the current level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign level      = level_q;
    assign rise_pulse = level_q & ~prev_q;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Dice roll controller: debounces the roll button, runs a decelerating tumble
// that samples the LFSR at doubling intervals, and holds the final result.
// Build option: define DICE_MOD6_EN to map each nibble to a dice face 1..6;
// otherwise raw nibbles 0..F are latched.
// Ports:
//   clk          - system clock
//   rst          - asynchronous active-high reset
//   roll_btn     - raw roll push-button
//   rnd          - current LFSR output
//   dice_val     - latched value, [7:4] digit 2, [3:0] digit 1
//   rolling      - tumble in progress
//   result_valid - final result held
//   match        - result held and both digits equal
//   roll_count   - completed rolls, wraps 255 -> 0
module dice_roll_ctrl
    import dice_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
    parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES,
    parameter int unsigned ROLL_STEPS  = DEF_ROLL_STEPS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       roll_btn,
    input  logic [7:0] rnd,
    output logic [7:0] dice_val,
    output logic       rolling,
    output logic       result_valid,
    output logic       match,
    output logic [7:0] roll_count
);

    // Sized so the final (longest) interval still fits.
    localparam int unsigned TW = $clog2(STEP_CYCLES << (ROLL_STEPS - 1)) + 1;
    localparam int unsigned SW = $clog2(ROLL_STEPS) + 1;

    logic roll_req;

    // Debounced level is not needed here; only the press edge starts a roll.
    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (roll_btn),
        .level      (),
        .rise_pulse (roll_req)
    );

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] interval_q, interval_d;
    logic [SW-1:0] step_q, step_d;
    logic [7:0]    dice_q, dice_d;
    logic          rolling_q, rolling_d;
    logic          valid_q, valid_d;
    logic [7:0]    count_q, count_d;
    logic [7:0]    sample;

`ifdef DICE_MOD6_EN
    assign sample = {mod6_face(rnd[7:4]), mod6_face(rnd[3:0])};
`else
    assign sample = rnd;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            interval_q <= '0;
            step_q     <= '0;
            dice_q     <= 8'h00;
            rolling_q  <= 1'b0;
            valid_q    <= 1'b0;
            count_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            interval_q <= interval_d;
            step_q     <= step_d;
            dice_q     <= dice_d;
            rolling_q  <= rolling_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        interval_d = interval_q;
        step_d     = step_q;
        dice_d     = dice_q;
        rolling_d  = rolling_q;
        valid_d    = valid_q;
        count_d    = count_q;
        unique case (state_q)
            StIdle, StHold: begin
                if (roll_req) begin
                    state_d    = StRoll;
                    timer_d    = '0;
                    step_d     = '0;
                    interval_d = TW'(STEP_CYCLES);
                    rolling_d  = 1'b1;
                    valid_d    = 1'b0;
                end
            end
            StRoll: begin
                // roll_req is deliberately ignored while tumbling.
                if (timer_q == interval_q - TW'(1)) begin
                    dice_d     = sample;
                    timer_d    = '0;
                    interval_d = interval_q << 1;
                    step_d     = step_q + SW'(1);
                    if (step_q == SW'(ROLL_STEPS - 1)) begin
                        state_d   = StHold;
                        rolling_d = 1'b0;
                        valid_d   = 1'b1;
                        count_d   = count_q + 8'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign dice_val     = dice_q;
    assign rolling      = rolling_q;
    assign result_valid = valid_q;
    assign roll_count   = count_q;
    assign match        = valid_q & (dice_q[7:4] == dice_q[3:0]);

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl with DB_CYCLES=4, STEP_CYCLES=2,
// ROLL_STEPS=3 (tumble lasts 2+4+8 = 14 cycles). Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_dice_roll_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       roll_btn;
    logic [7:0] rnd;
    logic [7:0] dice_val;
    logic       rolling;
    logic       result_valid;
    logic       match;
    logic [7:0] roll_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit glitch  = 1'b0;

    dice_roll_ctrl #(
        .DB_CYCLES   (4),
        .STEP_CYCLES (2),
        .ROLL_STEPS  (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .roll_btn     (roll_btn),
        .rnd          (rnd),
        .dice_val     (dice_val),
        .rolling      (rolling),
        .result_valid (result_valid),
        .match        (match),
        .roll_count   (roll_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Press and wait (bounded) for rolling; returns cycles waited.
    task automatic wait_rolling(input bit watch, output int n);
        n = 0;
        while (rolling !== 1'b1 && n < 40) begin
            if (watch && result_valid !== 1'b1) glitch = 1'b1;
            tick();
            n++;
        end
    endtask

    task automatic run_roll(input logic [7:0] r, input bit watch);
        int n;
        roll_btn = 1'b1;
        rnd      = r;
        wait_rolling(watch, n);
        check_eq("roll_start", 32'(rolling), 1);
        roll_btn = 1'b0;
        repeat (14) tick();
        check_eq("roll_done", 32'({rolling, result_valid}), 32'b01);
    endtask

    initial begin
        int n;
        int bad;
        int len;

        rst      = 1'b1;
        roll_btn = 1'b0;
        rnd      = 8'h00;
        repeat (3) tick();
        check_eq("rst_dice", 32'(dice_val), 0);
        check_eq("rst_rolling", 32'(rolling), 0);
        check_eq("rst_valid", 32'(result_valid), 0);
        check_eq("rst_match", 32'(match), 0);
        check_eq("rst_count", 32'(roll_count), 0);
        rst = 1'b0;
        tick();

        // Bounce: toggle every 2 cycles, never 4 stable samples.
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            roll_btn = ((k / 2) % 2 == 0);
            tick();
            if (rolling !== 1'b0) bad++;
        end
        check_eq("bounce_quiet", 32'(bad), 0);
        roll_btn = 1'b1;
        wait_rolling(1'b0, n);
        // 2 sync edges + 4 debounce edges + 1 FSM edge
        check_eq("bounce_latency", 32'(n), 7);

        // Timing: samples at ends of ROLL cycles 2, 6 and 14.
        bad = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 1) roll_btn = 1'b0;
            rnd = (c == 2) ? 8'h12 : (c == 6) ? 8'h34 : (c == 14) ? 8'h5A : 8'hEE;
            if (rolling !== 1'b1) bad++;
            if (c == 3) check_eq("sample1", 32'(dice_val), 32'h12);
            if (c == 7) check_eq("sample2", 32'(dice_val), 32'h34);
            tick();
        end
        check_eq("roll_len", 32'(bad), 0);
        check_eq("t_rolling", 32'(rolling), 0);
        check_eq("t_valid", 32'(result_valid), 1);
        check_eq("t_dice", 32'(dice_val), 32'h5A);
        check_eq("t_match", 32'(match), 0);
        check_eq("t_count", 32'(roll_count), 1);

        // Match, then a non-matching roll.
        run_roll(8'h33, 1'b0);
        check_eq("m_dice", 32'(dice_val), 32'h33);
        check_eq("m_match", 32'(match), 1);
        check_eq("m_count", 32'(roll_count), 2);
        roll_btn = 1'b1;
        rnd      = 8'h34;
        wait_rolling(1'b0, n);
        check_eq("m2_start", 32'(rolling), 1);
        check_eq("m2_valid_drop", 32'(result_valid), 0);
        check_eq("m2_match_drop", 32'(match), 0);
        roll_btn = 1'b0;
        repeat (14) tick();
        check_eq("m2_dice", 32'(dice_val), 32'h34);
        check_eq("m2_match", 32'(match), 0);
        check_eq("m2_count", 32'(roll_count), 3);

        // Second press lands in ROLL cycle 13 and must be ignored.
        roll_btn = 1'b1;
        rnd      = 8'h21;
        wait_rolling(1'b0, n);
        len = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 1) roll_btn = 1'b0;
            if (c == 7) roll_btn = 1'b1;
            if (rolling === 1'b1) len++;
            tick();
        end
        check_eq("ign_len", 32'(len), 14);
        check_eq("ign_count", 32'(roll_count), 4);
        roll_btn = 1'b0;
        repeat (10) tick();

        // Reset at ROLL cycle 5 with the button held.
        roll_btn = 1'b1;
        rnd      = 8'h77;
        wait_rolling(1'b0, n);
        repeat (4) tick();
        check_eq("pre_rst_dice", 32'(dice_val), 32'h77);
        rst = 1'b1;
        #1;
        check_eq("arst_dice", 32'(dice_val), 0);
        check_eq("arst_rolling", 32'(rolling), 0);
        check_eq("arst_valid", 32'(result_valid), 0);
        check_eq("arst_match", 32'(match), 0);
        check_eq("arst_count", 32'(roll_count), 0);
        repeat (2) tick();
        rst = 1'b0;
        wait_rolling(1'b0, n);
        check_eq("held_latency", 32'(n), 7);
        roll_btn = 1'b0;
        repeat (14) tick();
        check_eq("held_done", 32'({rolling, result_valid}), 32'b01);
        check_eq("held_count", 32'(roll_count), 1);

        // Nibble mapping.
        run_roll(8'hF0, 1'b0);
`ifdef DICE_MOD6_EN
        check_eq("map_f0", 32'(dice_val), 32'h41);
`else
        check_eq("map_f0", 32'(dice_val), 32'hF0);
`endif
        run_roll(8'h66, 1'b0);
`ifdef DICE_MOD6_EN
        check_eq("map_66", 32'(dice_val), 32'h11);
`else
        check_eq("map_66", 32'(dice_val), 32'h66);
`endif
        check_eq("map_66_match", 32'(match), 1);
        check_eq("map_count", 32'(roll_count), 3);

        // Wrap: 256 rolls from reset; result_valid must stay high between rolls.
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        glitch = 1'b0;
        for (int i = 0; i < 256; i++) begin
            run_roll(8'(i), i > 0);
            if (i == 254) check_eq("wrap_255", 32'(roll_count), 255);
            repeat (3) begin
                if (result_valid !== 1'b1) glitch = 1'b1;
                tick();
            end
        end
        check_eq("wrap_zero", 32'(roll_count), 0);
        check_eq("wrap_valid", 32'(result_valid), 1);
        check_eq("wrap_glitch", 32'(glitch), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
